// File: rtl/fetch_stage_if.sv
// fetch_stage_if: signal bundle between the fetch stage and its neighbours
// (hazard unit, EX redirect, program loader, ID stage).
//
// master modport: the surrounding pipeline / loader. Drives stall,
//   branch_taken, branch_target, prog_we, prog_addr and prog_data.
//   Observes PC, the IF/ID register, halted and the state debug bit.
// slave modport: the fetch stage itself, with the directions reversed.
//
// IF/ID qualifier: IFID_Valid=1 means IFID_InstrReg/IFID_PCplus2 hold a
// real fetched instruction; IFID_Valid=0 means the register holds a bubble
// (NOP_WORD). ID takes the register every edge it is not stalled; there is
// no ready back-pressure other than the stall input.
interface fetch_stage_if #(
  parameter int IMEM_AW = 8
);
  logic               stall;
  logic               branch_taken;
  logic [15:0]        branch_target;
  logic               prog_we;
  logic [IMEM_AW-1:0] prog_addr;
  logic [15:0]        prog_data;
  logic [15:0]        PC;
  logic [15:0]        IFID_InstrReg;
  logic [15:0]        IFID_PCplus2;
  logic               IFID_Valid;
  logic               halted;
  logic               state_dbg;   // 0 = RUN, 1 = HALT

  modport master (
    output stall, branch_taken, branch_target, prog_we, prog_addr, prog_data,
    input  PC, IFID_InstrReg, IFID_PCplus2, IFID_Valid, halted, state_dbg
  );

  modport slave (
    input  stall, branch_taken, branch_target, prog_we, prog_addr, prog_data,
    output PC, IFID_InstrReg, IFID_PCplus2, IFID_Valid, halted, state_dbg
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 16-bit five-stage pipeline.
// Holds the PC, the instruction memory and the IF/ID pipeline register.
//
// Ports:
//   clock  - system clock, all updates on the rising edge
//   resetn - asynchronous active-low reset
//   bus    - fetch_stage_if.slave: stall / branch redirect / program load
//            inputs, PC, IF/ID register, halted and state debug outputs
//
// Per-edge priority: program load > branch redirect > stall > fetch (RUN)
// or bubble (HALT). All outputs come straight from flops.
module fetch_stage #(
  parameter int          IMEM_AW   = 8,
  parameter logic [15:0] HALT_WORD = 16'hFFFF,
  parameter logic [15:0] NOP_WORD  = 16'h0000
) (
  input  logic          clock,
  input  logic          resetn,
  fetch_stage_if.slave  bus
);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  localparam int DEPTH = 2 ** IMEM_AW;

  // Instruction memory: not reset, synchronous write, combinational read.
  logic [15:0] imem [DEPTH];

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pcp2_q, pcp2_d;
  logic        valid_q, valid_d;

  logic [15:0] fetch_word;
  logic [15:0] pc_plus2;
  logic        unused_bt0;

  // Word index drops the byte bit and ignores PC bits above IMEM_AW, so
  // high addresses alias onto the memory.
  assign fetch_word = imem[pc_q[IMEM_AW:1]];
  assign pc_plus2   = pc_q + 16'd2;   // wraps 16'hFFFE -> 16'h0000
  assign unused_bt0 = bus.branch_target[0];

  // A write and a fetch of the same word in one cycle cannot both take
  // effect (a load freezes fetch), and the read sees pre-edge contents.
  always_ff @(posedge clock) begin
    if (bus.prog_we) begin
      imem[bus.prog_addr] <= bus.prog_data;
    end
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_RUN;
      pc_q    <= 16'h0000;
      instr_q <= NOP_WORD;
      pcp2_q  <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp2_q  <= pcp2_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp2_d  = pcp2_q;
    valid_d = valid_q;
    if (bus.prog_we) begin
      // Loading freezes fetch completely, including a pending redirect.
    end else if (bus.branch_taken) begin
      // The redirecting branch is older than any halt, so it also wakes
      // the stage. IFID_PCplus2 deliberately keeps its old value.
      pc_d    = {bus.branch_target[15:1], 1'b0};
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      state_d = S_RUN;
    end else if (bus.stall) begin
      // hold everything
    end else if (state_q == S_RUN) begin
      instr_d = fetch_word;
      pcp2_d  = pc_plus2;
      valid_d = 1'b1;
      if (fetch_word == HALT_WORD) begin
        // HALT itself goes down the pipe; PC parks on it.
        state_d = S_HALT;
      end else begin
        pc_d = pc_plus2;
      end
    end else begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    bus.PC            = pc_q;
    bus.IFID_InstrReg = instr_q;
    bus.IFID_PCplus2  = pcp2_q;
    bus.IFID_Valid    = valid_q;
    bus.halted        = (state_q == S_HALT);
    bus.state_dbg     = state_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test-plan sequences followed by randomized
// traffic, all compared against a behavioural model of the fetch stage.
module tb_fetch_stage;

  localparam int AW = 8;

  logic clock;
  logic resetn;

  fetch_stage_if #(.IMEM_AW(AW)) bus ();

  fetch_stage #(
    .IMEM_AW  (AW),
    .HALT_WORD(16'hFFFF),
    .NOP_WORD (16'h0000)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- model state ----------------
  logic [15:0] mem_m [256];
  logic [15:0] pc_m, ir_m, pcp2_m;
  logic        valid_m, halted_m;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pc"},     bus.PC,            pc_m);
    check({tag, ".ir"},     bus.IFID_InstrReg, ir_m);
    check({tag, ".pcp2"},   bus.IFID_PCplus2,  pcp2_m);
    check({tag, ".valid"},  {15'd0, bus.IFID_Valid}, {15'd0, valid_m});
    check({tag, ".halted"}, {15'd0, bus.halted},     {15'd0, halted_m});
  endtask

  task automatic model_reset();
    pc_m = 16'h0000; ir_m = 16'h0000; pcp2_m = 16'h0000;
    valid_m = 1'b0; halted_m = 1'b0;
  endtask

  // One rising edge of the fetch stage, expressed directly from the
  // behavioural rules (load, redirect, stall, fetch, halted bubble).
  task automatic model_edge();
    logic [15:0] w;
    if (bus.prog_we) begin
      mem_m[bus.prog_addr] = bus.prog_data;
    end else if (bus.branch_taken) begin
      pc_m = bus.branch_target & 16'hFFFE;
      ir_m = 16'h0000;
      valid_m = 1'b0;
      halted_m = 1'b0;
    end else if (bus.stall) begin
      // nothing moves
    end else if (!halted_m) begin
      w = mem_m[(pc_m / 2) % 256];
      ir_m = w;
      pcp2_m = pc_m + 16'd2;
      valid_m = 1'b1;
      if (w == 16'hFFFF) halted_m = 1'b1;
      else pc_m = pc_m + 16'd2;
    end else begin
      ir_m = 16'h0000;
      valid_m = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic st, input logic br, input logic [15:0] tgt,
                       input logic we, input logic [7:0] wa, input logic [15:0] wd);
    bus.stall = st;
    bus.branch_taken = br;
    bus.branch_target = tgt;
    bus.prog_we = we;
    bus.prog_addr = wa;
    bus.prog_data = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000);
  endtask

  // Apply one edge to model and DUT, then compare away from the edge.
  task automatic step(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    compare_all(tag);
  endtask

  task automatic load_word(input logic [7:0] a, input logic [15:0] d);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, a, d);
    step("load");
    idle();
  endtask

  task automatic branch_to(input logic [15:0] tgt);
    drive(1'b0, 1'b1, tgt, 1'b0, 8'h00, 16'h0000);
    step("branch");
    idle();
  endtask

  // ---------------- main sequence ----------------
  logic [15:0] d;

  initial begin
    idle();
    resetn = 1'b0;
    model_reset();
    #23;
    compare_all("reset");
    @(negedge clock);
    resetn = 1'b1;

    // Fill the whole memory so nothing is unknown; no HALT words yet.
    for (int i = 0; i < 256; i++) begin
      d = 16'($urandom_range(0, 16'hFFFE));
      if (i == 0) d = 16'h1111;
      if (i == 1) d = 16'h2222;
      if (i == 2) d = 16'h3333;
      if (i == 3) d = 16'h4444;
      load_word(8'(i), d);
    end
    check("load_freezes_pc", bus.PC, 16'h0000);

    // Sequential fetch
    step("seq0");
    check("seq0_ir", bus.IFID_InstrReg, 16'h1111);
    step("seq1");
    check("seq1_ir", bus.IFID_InstrReg, 16'h2222);
    check("seq1_pc", bus.PC, 16'h0004);

    // Stall for two edges while IFID=2222, PC=4
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000);
    step("stall0");
    step("stall1");
    check("stall_ir", bus.IFID_InstrReg, 16'h2222);
    check("stall_pc", bus.PC, 16'h0004);
    idle();
    step("unstall");
    check("unstall_ir", bus.IFID_InstrReg, 16'h3333);
    check("unstall_pc", bus.PC, 16'h0006);

    // Branch together with stall: branch wins
    drive(1'b1, 1'b1, 16'h0011, 1'b0, 8'h00, 16'h0000);
    step("brstall");
    check("brstall_pc", bus.PC, 16'h0010);
    check("brstall_ir", bus.IFID_InstrReg, 16'h0000);
    idle();
    step("brtarget");
    check("brtarget_ir", bus.IFID_InstrReg, mem_m[8]);

    // Halt on word 2
    load_word(8'd2, 16'hFFFF);
    branch_to(16'h0000);
    step("h0");
    step("h1");
    step("h2");
    check("halt_ir", bus.IFID_InstrReg, 16'hFFFF);
    check("halt_flag", {15'd0, bus.halted}, 16'h0001);
    check("halt_pc", bus.PC, 16'h0004);
    step("h3");
    step("h4");
    check("halt_bubble_valid", {15'd0, bus.IFID_Valid}, 16'h0000);
    branch_to(16'h0000);
    check("unhalt_flag", {15'd0, bus.halted}, 16'h0000);
    step("resume");
    check("resume_ir", bus.IFID_InstrReg, 16'h1111);
    load_word(8'd2, 16'h3333);

    // Wrap
    branch_to(16'hFFFE);
    step("wrap");
    check("wrap_pc", bus.PC, 16'h0000);
    check("wrap_ir", bus.IFID_InstrReg, mem_m[255]);

    // Load with branch: load wins, memory written
    drive(1'b0, 1'b1, 16'h0040, 1'b1, 8'd5, 16'h5A5A);
    step("freeze");
    check("freeze_pc", bus.PC, 16'h0000);
    idle();
    branch_to(16'h000A);
    step("freeze_read");
    check("freeze_read_ir", bus.IFID_InstrReg, 16'h5A5A);

    // Random traffic, HALT words sprinkled in
    for (int k = 0; k < 400; k++) begin
      d = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0, 16'($urandom),
            $urandom_range(0, 9) == 0, 8'($urandom), d);
      step("rand");
    end
    idle();
    step("rand_tail");

    // Asynchronous reset in mid-cycle
    @(posedge clock);
    #3;
    resetn = 1'b0;
    model_reset();
    #1;
    compare_all("async");
    @(negedge clock);
    resetn = 1'b1;
    branch_to(16'h0000);  // model: ensure nothing halted; keeps sequence plain
    step("post_reset");
    check("post_reset_ir", bus.IFID_InstrReg, mem_m[0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit five-stage pipelined CPU; feeds the ID stage.
- Holds the PC, the instruction memory and the IF/ID pipeline register.
- Handles load-use stalls from hazard detection and taken-branch redirects from EX, with a flush.
- Detects a HALT word and stops fetching.

Parameters:
- IMEM_AW, 8, instruction memory word-address bits; depth = 2**IMEM_AW 16-bit words.
- HALT_WORD, 16'hFFFF, instruction encoding that stops fetch.
- NOP_WORD, 16'h0000, bubble encoding inserted on reset, flush and halt.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- stall  input  1  hazard unit request: hold PC and IF/ID.
- branch_taken  input  1  EX-stage taken branch or jump: redirect and flush.
- branch_target  input  16  redirect byte address.
- prog_we  input  1  instruction memory load strobe.
- prog_addr  input  IMEM_AW  load word address.
- prog_data  input  16  load data.
- PC  output  16  current fetch byte address.
- IFID_InstrReg  output  16  IF/ID instruction register.
- IFID_PCplus2  output  16  IF/ID PC+2, used by ID/EX for branch offsets.
- IFID_Valid  output  1  IF/ID holds a real fetched instruction.
- halted  output  1  fetch stopped on HALT_WORD.

Behaviour:
- Reset (resetn=0, asynchronous):
  - PC=0, IFID_InstrReg=NOP_WORD, IFID_PCplus2=0, IFID_Valid=0, halted=0, state=RUN.
  - Memory contents are not reset.
- Memory:
  - Word index = PC[IMEM_AW:1]. PC bit 0 and bits above IMEM_AW are ignored, so aliasing is permitted.
  - Read is combinational from PC.
  - Write is synchronous on prog_we.
  - Same-cycle write and fetch of the same word returns the old data.
- Byte addressing: PC advances by 2 and wraps 16'hFFFE -> 16'h0000. branch_target bit 0 is forced to 0.
- States: RUN, HALT. Action priority per rising edge, highest first:
  1. prog_we=1: memory write only. PC, IF/ID and state hold, even if branch_taken=1. Loading freezes fetch.
  2. branch_taken=1:
     - PC <= {branch_target[15:1],1'b0}; IFID_InstrReg <= NOP_WORD; IFID_Valid <= 0; IFID_PCplus2 holds.
     - state <= RUN, halted <= 0. This overrides stall and leaves HALT, since the redirecting branch is older than the halt.
  3. stall=1: PC, IF/ID and state hold.
  4. RUN, normal fetch:
     - IFID_InstrReg <= imem[idx]; IFID_PCplus2 <= PC+2; IFID_Valid <= 1.
     - If the fetched word equals HALT_WORD: PC holds, state <= HALT, halted <= 1. The HALT word itself is passed down the pipe.
     - Otherwise PC <= PC+2.
  5. HALT, no stall/branch: PC holds; IFID_InstrReg <= NOP_WORD; IFID_Valid <= 0.
- Latency:
  - Instruction at PC appears on IFID_InstrReg one edge after fetch.
  - A branch asserted at edge N gives the target instruction in IF/ID at edge N+1 and a NOP at edge N.
  - Exactly one bubble per taken branch.
- Reset deasserted mid-stream: first edge after release fetches address 0.
- Outputs PC, IFID_* and halted are registers, never combinational from inputs.

Test Plan:
- Sequential fetch:
  - Stimulus: load words 0..3 = 1111,2222,3333,4444; release; run 4 edges.
  - Required: PC goes 0,2,4,6,8; IFID_InstrReg goes 1111,2222,3333,4444; IFID_PCplus2 goes 2,4,6,8; Valid=1.
- Stall:
  - Stimulus: stall=1 for 2 edges while IFID=2222, PC=4.
  - Required: both hold for 2 edges; next edge gives IFID=3333, PC=6.
- Branch with stall:
  - Stimulus: at PC=6, branch_taken=1 and stall=1, target=16'h0011.
  - Required: PC=0x0010, IFID=NOP_WORD, Valid=0; next edge IFID=imem[8].
- Halt:
  - Stimulus: word 2 = FFFF.
  - Required: IFID=FFFF with Valid=1 and halted=1, PC stuck at 4. Subsequent edges give NOP with Valid=0.
  - Then branch_taken with target 0 -> halted=0, fetch resumes at 0.
- Wrap and freeze:
  - Stimulus: branch to 16'hFFFE, then one fetch.
  - Required: PC=0x0000, instruction taken from index 255 (IMEM_AW=8).
  - Then prog_we=1 with branch_taken=1 -> PC and IF/ID unchanged, memory written.
- Async reset:
  - Stimulus: drop resetn mid-cycle while running.
  - Required: outputs go to reset values immediately, before the next edge.
